alu_top: RTL and testbench
==========================

Name: alu_top

Overview:
- Board-level wrapper around a combinational 8-bit ALU.
- Operand A, operand B and a 6-bit opcode are each captured from the slide switches into their own register by a dedicated push-button.
- The ALU result drives the LEDs continuously.
- Top of the FPGA hierarchy, clocked by the 100 MHz board clock.

Parameters:
- OPERAND_SIZE, 8, width of operands A/B, switch bus and result.
- OP_CODE_SIZE, 6, width of opcode register; taken from sw[OP_CODE_SIZE-1:0].

Ports:
- CLK100MHZ  input  1  system clock, all registers update on rising edge.
- btnU  input  1  reset, synchronous, active-high.
- sw  input  OPERAND_SIZE  data switches.
- btnL  input  1  load operand A from sw.
- btnC  input  1  load operand B from sw.
- btnR  input  1  load opcode from sw[OP_CODE_SIZE-1:0].
- LED  output  OPERAND_SIZE  ALU result.

Behaviour:
- One clock domain (CLK100MHZ); reset is synchronous and active-high (btnU); no asynchronous logic.
- Registers:
  - reg_a[7:0], reg_b[7:0], reg_op[5:0].
  - btnU high at rising edge: all three cleared to 0; reset has priority over any load button.
- Loads (level-sensitive, no debouncing or edge detection):
  - btnL high at rising edge: reg_a <= sw.
  - btnC high at rising edge: reg_b <= sw.
  - btnR high at rising edge: reg_op <= sw[5:0]; sw[7:6] ignored.
  - Buttons are independent; several high in one cycle all load the same sw value.
  - A held button reloads every cycle.
- ALU: purely combinational from reg_a, reg_b, reg_op; LED = result. LED is valid in the cycle after the last load edge (no extra pipeline stage).
- Opcodes, MIPS funct encoding:
  - 100000 ADD: A+B, modulo 256, carry discarded.
  - 100010 SUB: A-B, modulo 256 (two's complement wrap).
  - 100100 AND: A & B.
  - 100101 OR: A | B.
  - 100110 XOR: A ^ B.
  - 100111 NOR: ~(A | B).
  - 000011 SRA: A arithmetic right shift by B. Shift amount is the unsigned value of B; B >= 8 yields all copies of A[7].
  - 000010 SRL: A logical right shift by B; B >= 8 yields 0.
  - Any other opcode (including reset value 000000): result 0.
- Reset value of LED: 0 (reset opcode 000000 is undefined and yields 0).
- Reset mid-operation: all registers clear on that edge, LED becomes 0 immediately after; loads asserted in the same cycle are ignored.
- No flags, overflow or status outputs.

Test Plan:
- Reset: btnU=1 for one edge with btnL/btnC/btnR also high and sw=8'hFF -> LED=8'h00, registers stay 0.
- AND: sw=8'h49, btnL one edge; sw=8'h48, btnC one edge; sw=8'h24 (100100), btnR one edge -> LED=8'h48.
- OR, opcode changed without reloading operands: sw=8'h25, btnR -> LED=8'h49. Then reload A=8'h0F, B=8'hF0 -> LED=8'hFF.
- ADD/SUB wrap:
  - A=8'hF0, B=8'h20, op=100000 -> LED=8'h10.
  - op=100010 with A=8'h05, B=8'h07 -> LED=8'hFE.
- Shifts:
  - A=8'h90, B=8'h02: op=000011 -> 8'hE4; op=000010 -> 8'h24.
  - B=8'h09: SRA -> 8'hFF; SRL -> 8'h00.
- Undefined opcode and simultaneous load:
  - op=111111 -> LED=8'h00.
  - btnL and btnC high in the same cycle with sw=8'h33, op=XOR (100110) -> LED=8'h00; NOR -> 8'hCC.

Source files
------------

// File: rtl/alu_top.sv
// Board-level wrapper: operands and opcode latched from switches by push-buttons,
// combinational 8-bit ALU result shown on the LEDs.
module alu_top #(
    parameter int unsigned OPERAND_SIZE = 8,
    parameter int unsigned OP_CODE_SIZE = 6
) (
    input  logic                    CLK100MHZ,
    input  logic                    btnU,
    input  logic [OPERAND_SIZE-1:0] sw,
    input  logic                    btnL,
    input  logic                    btnC,
    input  logic                    btnR,
    output logic [OPERAND_SIZE-1:0] LED
);

    // MIPS funct-field encodings
    localparam logic [OP_CODE_SIZE-1:0] OP_ADD = OP_CODE_SIZE'(6'b100000);
    localparam logic [OP_CODE_SIZE-1:0] OP_SUB = OP_CODE_SIZE'(6'b100010);
    localparam logic [OP_CODE_SIZE-1:0] OP_AND = OP_CODE_SIZE'(6'b100100);
    localparam logic [OP_CODE_SIZE-1:0] OP_OR  = OP_CODE_SIZE'(6'b100101);
    localparam logic [OP_CODE_SIZE-1:0] OP_XOR = OP_CODE_SIZE'(6'b100110);
    localparam logic [OP_CODE_SIZE-1:0] OP_NOR = OP_CODE_SIZE'(6'b100111);
    localparam logic [OP_CODE_SIZE-1:0] OP_SRA = OP_CODE_SIZE'(6'b000011);
    localparam logic [OP_CODE_SIZE-1:0] OP_SRL = OP_CODE_SIZE'(6'b000010);

    logic [OPERAND_SIZE-1:0] reg_a;
    logic [OPERAND_SIZE-1:0] reg_b;
    logic [OP_CODE_SIZE-1:0] reg_op;
    logic [OPERAND_SIZE-1:0] result;

    // Buttons are level-sensitive; a held button reloads every cycle.
    always_ff @(posedge CLK100MHZ) begin
        if (btnU) begin
            reg_a  <= '0;
            reg_b  <= '0;
            reg_op <= '0;
        end else begin
            if (btnL) reg_a  <= sw;
            if (btnC) reg_b  <= sw;
            if (btnR) reg_op <= sw[OP_CODE_SIZE-1:0];
        end
    end

    always_comb begin
        result = '0;
        case (reg_op)
            OP_ADD:  result = reg_a + reg_b;
            OP_SUB:  result = reg_a - reg_b;
            OP_AND:  result = reg_a & reg_b;
            OP_OR:   result = reg_a | reg_b;
            OP_XOR:  result = reg_a ^ reg_b;
            OP_NOR:  result = ~(reg_a | reg_b);
            // Shift amount is the full unsigned B; oversized shifts saturate.
            OP_SRA:  result = $unsigned($signed(reg_a) >>> reg_b);
            OP_SRL:  result = reg_a >> reg_b;
            default: result = '0;
        endcase
    end

    assign LED = result;

endmodule

// File: tb/tb_alu_top.sv
// Directed table-driven bench for alu_top: each record drives one clock edge of
// switches/buttons and gives the LED value expected just after that edge.
module tb_alu_top;

    logic       clk = 1'b0;
    logic       btn_u = 1'b0;
    logic       btn_l = 1'b0;
    logic       btn_c = 1'b0;
    logic       btn_r = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] led;

    int n_applied = 0;
    int n_miscompares = 0;

    typedef struct {
        logic [7:0] sw;
        logic       u;
        logic       l;
        logic       c;
        logic       r;
        logic [7:0] exp;
        string      name;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs[NVEC];

    alu_top #(
        .OPERAND_SIZE(8),
        .OP_CODE_SIZE(6)
    ) dut (
        .CLK100MHZ(clk),
        .btnU     (btn_u),
        .sw       (sw),
        .btnL     (btn_l),
        .btnC     (btn_c),
        .btnR     (btn_r),
        .LED      (led)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] s, input logic u, input logic l,
                                input logic c, input logic r, input logic [7:0] e,
                                input string n);
        vec_t v;
        v.sw = s; v.u = u; v.l = l; v.c = c; v.r = r; v.exp = e; v.name = n;
        return v;
    endfunction

    // Drive inputs away from the edge, clock once, sample 1 ns after the edge.
    task automatic apply(input logic [7:0] s, input logic u, input logic l, input logic c,
                         input logic r, input logic [7:0] e, input string n);
        @(negedge clk);
        sw = s; btn_u = u; btn_l = l; btn_c = c; btn_r = r;
        @(posedge clk);
        #1;
        n_applied++;
        if (led !== e) begin
            n_miscompares++;
            $display("FAIL %s: LED=%h expected %h", n, led, e);
        end
    endtask

    initial begin
        vecs[0]  = mk(8'hFF, 1, 1, 1, 1, 8'h00, "reset_priority");
        vecs[1]  = mk(8'h27, 0, 0, 0, 1, 8'hFF, "nor_after_reset");
        vecs[2]  = mk(8'h49, 0, 1, 0, 0, 8'hB6, "load_a_49");
        vecs[3]  = mk(8'h48, 0, 0, 1, 0, 8'hB6, "load_b_48");
        vecs[4]  = mk(8'h24, 0, 0, 0, 1, 8'h48, "and");
        vecs[5]  = mk(8'h25, 0, 0, 0, 1, 8'h49, "or_op_only");
        vecs[6]  = mk(8'h0F, 0, 1, 0, 0, 8'h4F, "or_load_a_0f");
        vecs[7]  = mk(8'hF0, 0, 0, 1, 0, 8'hFF, "or_load_b_f0");
        vecs[8]  = mk(8'hF0, 0, 1, 0, 0, 8'hF0, "or_load_a_f0");
        vecs[9]  = mk(8'h20, 0, 0, 1, 0, 8'hF0, "or_load_b_20");
        vecs[10] = mk(8'h20, 0, 0, 0, 1, 8'h10, "add_wrap");
        vecs[11] = mk(8'h05, 0, 1, 0, 0, 8'h25, "add_a_05");
        vecs[12] = mk(8'h07, 0, 0, 1, 0, 8'h0C, "add_b_07");
        vecs[13] = mk(8'h22, 0, 0, 0, 1, 8'hFE, "sub_wrap");
        vecs[14] = mk(8'h90, 0, 1, 0, 0, 8'h89, "sub_a_90");
        vecs[15] = mk(8'h02, 0, 0, 1, 0, 8'h8E, "sub_b_02");
        vecs[16] = mk(8'h03, 0, 0, 0, 1, 8'hE4, "sra_2");
        vecs[17] = mk(8'h02, 0, 0, 0, 1, 8'h24, "srl_2");
        vecs[18] = mk(8'h09, 0, 0, 1, 0, 8'h00, "srl_9");
        vecs[19] = mk(8'h03, 0, 0, 0, 1, 8'hFF, "sra_9");
        vecs[20] = mk(8'h3F, 0, 0, 0, 1, 8'h00, "undefined_op");
        vecs[21] = mk(8'hE6, 0, 0, 0, 1, 8'h99, "xor_sw76_ignored");
        vecs[22] = mk(8'h33, 0, 1, 1, 0, 8'h00, "xor_simul_load");
        vecs[23] = mk(8'h27, 0, 0, 0, 1, 8'hCC, "nor_simul_load");
        vecs[24] = mk(8'hFF, 1, 1, 0, 0, 8'h00, "reset_mid_op");
        vecs[25] = mk(8'h27, 0, 0, 0, 1, 8'hFF, "regs_cleared");

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].sw, vecs[i].u, vecs[i].l, vecs[i].c, vecs[i].r, vecs[i].exp,
                  vecs[i].name);
        end

        // Held btnL reloads A each cycle; op is NOR with B = 0.
        apply(8'h0F, 0, 1, 0, 0, 8'hF0, "held_l_1");
        apply(8'h3C, 0, 1, 0, 0, 8'hC3, "held_l_2");
        apply(8'hFF, 0, 0, 0, 0, 8'hC3, "released_l");

        // Nothing pressed: registers hold across several cycles.
        apply(8'h00, 0, 0, 0, 0, 8'hC3, "idle_hold_1");
        apply(8'hAA, 0, 0, 0, 0, 8'hC3, "idle_hold_2");

        // Reset held for two edges with loads asserted, then ADD of zeros.
        apply(8'h5A, 1, 1, 1, 1, 8'h00, "reset_hold_1");
        apply(8'h5A, 1, 1, 1, 1, 8'h00, "reset_hold_2");
        apply(8'h20, 0, 0, 0, 1, 8'h00, "add_zeros");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
